hazard_scoreboard: RTL
======================

// Module: hazard_scoreboard
// PURPOSE
//  Parametrised D-stage hazard unit for the MIPS pipeline. Replaces per-stage Tnew compares with a
//  per-register countdown scoreboard. Also tracks MDU occupancy and CP0 serialisation.
//  Drives one global stall to IFU/D-reg/E-reg and a per-cause vector.
// PARAMETERS
//  NUM_SRC   2   D-stage source operands checked per cycle
//  REG_AW    5   register address width; register 0 never tracked
//  TW        2   Tuse/Tnew/counter width
//  MULT_LAT  5   cycles MDU busy after mult/multu issue
//  DIV_LAT   10  cycles MDU busy after div/divu issue
//  CP0_LAT   1   cycles from mtc0 issue until CP0 write is visible to eret
//  PERF_W    32  perf counter width (STALL_PERF_EN only)
// PORTS
//  clk         in   1               pipeline clock
//  reset       in   1               asynchronous, active-high
//  d_valid     in   1               D holds a real instruction
//  d_src_addr  in   NUM_SRC*REG_AW  source regs, src i at [i*REG_AW +: REG_AW]
//  d_src_use   in   NUM_SRC         source i is read
//  d_src_tuse  in   NUM_SRC*TW      Tuse of source i
//  d_wr_en     in   1               D instr writes a GPR
//  d_wr_addr   in   REG_AW          destination GPR
//  d_tnew      in   TW              Tnew the instr will have on entering E
//  d_md_op     in   1               D instr is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
//  d_md_start  in   1               D instr starts MDU op (subset of d_md_op)
//  d_md_div    in   1               started op is div/divu (else mult)
//  d_cp0_wr    in   1               D instr is mtc0 to EPC
//  d_serial    in   1               D instr is eret
//  flush       in   1               exception/eret flush of D/E/M
//  perf_clr    in   1               clear perf counters
//  stall       out  1               freeze IFU and D reg, bubble into E
//  stall_cause out  3               [0] RAW, [1] MDU, [2] SERIAL
//  md_busy     out  1               md_cnt != 0
//  perf_stall / perf_raw / perf_md / perf_ser  out  PERF_W each  perf counters
// BEHAVIOUR
//  - issue = d_valid & ~stall & ~flush. All state updates occur at posedge clk.
//  - cnt[r] (TW bits, r=1..2^REG_AW-1) resets to 0 and loads d_tnew on issue & d_wr_en & d_wr_addr!=0.
//    Otherwise it decrements to 0 each cycle and saturates at 0. Load beats decrement on the same reg.
//    A newer writer overwrites an older pending entry.
//  - RAW[i] = d_valid & d_src_use[i] & addr_i!=0 & cnt[addr_i] > tuse_i. Uses pre-edge cnt.
//    D's own destination is never compared with its own sources.
//  - md_cnt (resets to 0) loads DIV_LAT or MULT_LAT on issue & d_md_start, else decrements to 0.
//    MDU stall = d_valid & d_md_op & md_cnt!=0.
//  - cp0_cnt (resets to 0) loads CP0_LAT on issue & d_cp0_wr, else decrements to 0.
//    SERIAL stall = d_valid & d_serial & cp0_cnt!=0.
//  - stall = OR of causes; stall_cause reports every active cause simultaneously. No priority.
//  - flush: all cnt[] and cp0_cnt clear to 0 next edge; md_cnt is NOT cleared (MDU runs to completion).
//    Stall is still computed combinationally in the flush cycle; no issue that cycle.
//  - reset mid-operation: all counters to 0 asynchronously; stall, stall_cause and md_busy read 0.
//  - stall is purely combinational from inputs + state: zero-cycle latency.
// CONFIGURATION
//  STALL_PERF_EN defined:
//    perf_stall increments each cycle with stall & d_valid & ~flush.
//    perf_raw, perf_md and perf_ser each increment when their cause bit is set.
//    All four counters saturate at all-ones; perf_clr zeroes them (clr wins over increment); reset zeroes them.
//  STALL_PERF_EN undefined: perf ports remain, tied to 0, no counter flops.
// STRUCTURE
//  - Shared package hazard_pkg: cause indices (CAUSE_RAW=0, CAUSE_MD=1, CAUSE_SER=2), cause width,
//    default latencies.
//  - Sub-module hazard_down_cnt (TW-wide load/decrement/saturate/clear counter) used for cnt[], md_cnt
//    and cp0_cnt. Width parametrised.
// TESTING
//  - lw $1 (tnew 2) issues, then addu using $1 (tuse 1): stall=1, cause=001 for 1 cycle, then issue.
//    tuse 0 (beq) -> 2 stall cycles.
//  - lw $0 followed by use of $0 -> never stall; write to $3, read $4 -> no stall.
//  - div issues, then mflo in D: stall with cause=010 for 10 cycles; md_busy falls with stall.
//    mult instead -> 5 cycles.
//  - mtc0 EPC issues, then eret: exactly 1 stall cycle cause=100. A flush in that cycle clears cp0_cnt:
//    no stall next cycle.
//  - pending $5 (cnt 2), lw $5 younger (tnew 2) reissues; reset asserted mid-countdown -> all outputs 0 at once.
//  - STALL_PERF_EN: 7 stall cycles -> perf_stall=7. perf_clr together with stall -> 0.
//    PERF_W=2 saturates at 3.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the D-stage hazard scoreboard: stall cause indices,
// default MDU/CP0 latencies and a counter-width helper.
package hazard_pkg;

  localparam int unsigned CAUSE_RAW = 0;
  localparam int unsigned CAUSE_MD  = 1;
  localparam int unsigned CAUSE_SER = 2;
  localparam int unsigned CAUSE_W   = 3;

  localparam int unsigned DEF_MULT_LAT = 5;
  localparam int unsigned DEF_DIV_LAT  = 10;
  localparam int unsigned DEF_CP0_LAT  = 1;

  typedef logic [CAUSE_W-1:0] cause_t;

  // Number of bits needed to hold max_val (at least 1).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) <= 64'(max_val)) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/hazard_down_cnt.sv
// Load / decrement-to-zero countdown used for per-register Tnew, MDU
// occupancy and CP0 write visibility. Priority: clear, load, decrement.
module hazard_down_cnt #(
  parameter int unsigned W = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear beats load, load beats the saturating decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Counter register, asynchronously cleared.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// D-stage hazard unit: per-register countdown scoreboard for RAW hazards,
// MDU occupancy tracking and mtc0->eret serialisation, producing one global
// stall plus a per-cause vector.
// Optional feature macro: STALL_PERF_EN (stall performance counters).
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_SRC  = 2,
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned TW       = 2,
  parameter int unsigned MULT_LAT = DEF_MULT_LAT,
  parameter int unsigned DIV_LAT  = DEF_DIV_LAT,
  parameter int unsigned CP0_LAT  = DEF_CP0_LAT,
  parameter int unsigned PERF_W   = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      d_valid,
  input  logic [NUM_SRC*REG_AW-1:0] d_src_addr,
  input  logic [NUM_SRC-1:0]        d_src_use,
  input  logic [NUM_SRC*TW-1:0]     d_src_tuse,
  input  logic                      d_wr_en,
  input  logic [REG_AW-1:0]         d_wr_addr,
  input  logic [TW-1:0]             d_tnew,
  input  logic                      d_md_op,
  input  logic                      d_md_start,
  input  logic                      d_md_div,
  input  logic                      d_cp0_wr,
  input  logic                      d_serial,
  input  logic                      flush,
  input  logic                      perf_clr,
  output logic                      stall,
  output logic [CAUSE_W-1:0]        stall_cause,
  output logic                      md_busy,
  output logic [PERF_W-1:0]         perf_stall,
  output logic [PERF_W-1:0]         perf_raw,
  output logic [PERF_W-1:0]         perf_md,
  output logic [PERF_W-1:0]         perf_ser
);

  localparam int unsigned NREG   = 1 << REG_AW;
  localparam int unsigned MD_MAX = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int unsigned MD_W   = cnt_width(MD_MAX);
  localparam int unsigned CP0_W  = cnt_width(CP0_LAT);

  logic                     issue;
  logic [NREG-1:0][TW-1:0]  cnt;
  logic [MD_W-1:0]          md_cnt;
  logic [CP0_W-1:0]         cp0_cnt;
  logic [NUM_SRC-1:0]       raw_vec;
  logic [REG_AW-1:0]        src_a;
  logic [TW-1:0]            src_t;
  cause_t                   cause;

  assign issue = d_valid & ~stall & ~flush;

  // Register 0 is hard-wired and never pending.
  assign cnt[0] = '0;

  for (genvar r = 1; r < NREG; r++) begin : g_reg
    hazard_down_cnt #(.W(TW)) u_cnt (
      .clk_i      (clk),
      .rst_i      (reset),
      .clr_i      (flush),
      .load_i     (issue & d_wr_en & (d_wr_addr == REG_AW'(r))),
      .load_val_i (d_tnew),
      .cnt_o      (cnt[r])
    );
  end

  // MDU keeps running across a flush, so it is never cleared.
  hazard_down_cnt #(.W(MD_W)) u_md_cnt (
    .clk_i      (clk),
    .rst_i      (reset),
    .clr_i      (1'b0),
    .load_i     (issue & d_md_start),
    .load_val_i (d_md_div ? MD_W'(DIV_LAT) : MD_W'(MULT_LAT)),
    .cnt_o      (md_cnt)
  );

  hazard_down_cnt #(.W(CP0_W)) u_cp0_cnt (
    .clk_i      (clk),
    .rst_i      (reset),
    .clr_i      (flush),
    .load_i     (issue & d_cp0_wr),
    .load_val_i (CP0_W'(CP0_LAT)),
    .cnt_o      (cp0_cnt)
  );

  // Per-source RAW check against the pre-edge countdown of its register.
  always_comb begin
    raw_vec = '0;
    src_a   = '0;
    src_t   = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      src_a      = d_src_addr[i*REG_AW +: REG_AW];
      src_t      = d_src_tuse[i*TW +: TW];
      raw_vec[i] = d_valid & d_src_use[i] & (src_a != '0) & (cnt[src_a] > src_t);
    end
  end

  // All causes reported together; the stall is their OR.
  always_comb begin
    cause            = '0;
    cause[CAUSE_RAW] = |raw_vec;
    cause[CAUSE_MD]  = d_valid & d_md_op & (md_cnt != '0);
    cause[CAUSE_SER] = d_valid & d_serial & (cp0_cnt != '0);
  end

  assign stall       = |cause;
  assign stall_cause = cause;
  assign md_busy     = (md_cnt != '0);

`ifdef STALL_PERF_EN
  logic [PERF_W-1:0] perf_stall_q, perf_stall_d;
  logic [PERF_W-1:0] perf_raw_q,   perf_raw_d;
  logic [PERF_W-1:0] perf_md_q,    perf_md_d;
  logic [PERF_W-1:0] perf_ser_q,   perf_ser_d;

  // Saturating event counters; clear takes precedence over counting.
  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_raw_d   = perf_raw_q;
    perf_md_d    = perf_md_q;
    perf_ser_d   = perf_ser_q;
    if (perf_clr) begin
      perf_stall_d = '0;
      perf_raw_d   = '0;
      perf_md_d    = '0;
      perf_ser_d   = '0;
    end else begin
      if (stall & d_valid & ~flush & ~&perf_stall_q) perf_stall_d = perf_stall_q + PERF_W'(1);
      if (cause[CAUSE_RAW] & ~&perf_raw_q)           perf_raw_d   = perf_raw_q + PERF_W'(1);
      if (cause[CAUSE_MD]  & ~&perf_md_q)            perf_md_d    = perf_md_q + PERF_W'(1);
      if (cause[CAUSE_SER] & ~&perf_ser_q)           perf_ser_d   = perf_ser_q + PERF_W'(1);
    end
  end

  // Perf counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_q <= '0;
      perf_raw_q   <= '0;
      perf_md_q    <= '0;
      perf_ser_q   <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_raw_q   <= perf_raw_d;
      perf_md_q    <= perf_md_d;
      perf_ser_q   <= perf_ser_d;
    end
  end

  assign perf_stall = perf_stall_q;
  assign perf_raw   = perf_raw_q;
  assign perf_md    = perf_md_q;
  assign perf_ser   = perf_ser_q;
`else
  logic unused_perf_clr;
  assign unused_perf_clr = perf_clr;
  assign perf_stall      = '0;
  assign perf_raw        = '0;
  assign perf_md         = '0;
  assign perf_ser        = '0;
`endif

endmodule
